// File: rtl/nr_divider_pipe_ctl.sv
// nr_divider_pipe_ctl: multi-cycle non-restoring divider with valid/ready handshakes.
// Retires K quotient bits per ITER cycle; signed and unsigned operation.
// Zero divisor and signed MIN/-1 produce defined results flagged by
// div_by_zero / overflow instead of iterating.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (in_ready high only when idle)
//   dividend, divisor         WIDTH-bit operands, sampled on accept
//   signed_op                 1 = two's-complement operation, sampled on accept
//   out_valid/out_ready       result handshake, result held until accepted
//   quotient, remainder       WIDTH-bit result, stable while out_valid
//   div_by_zero, overflow     result qualifiers, valid with out_valid
//   busy                      high from accept until result handshake completes
module nr_divider_pipe_ctl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 1,
  parameter int unsigned CNT_W = $clog2(WIDTH / K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned    N_ITER = WIDTH / K;
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ITER, S_CORRECT, S_HOLD
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   a_q;        // signed partial remainder, one guard bit
  logic [WIDTH-1:0] q_q;        // operand then quotient shift register
  logic [WIDTH-1:0] d_q;        // divisor (magnitude after SETUP)
  logic [CNT_W-1:0] cnt_q;
  logic             sop_q, sq_q, sr_q;
  logic             in_ready_q, busy_q, out_valid_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   a_d, a_sh;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_mag, q_fin, r_fin;

  // Magnitude of an operand; MIN maps onto itself, which reads as 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? WIDTH'(-x) : x;
  endfunction

  assign d_ext = {1'b0, d_q};

  // K chained non-restoring steps per ITER cycle.
  always_comb begin
    a_d  = a_q;
    q_d  = q_q;
    a_sh = '0;
    for (int unsigned i = 0; i < K; i++) begin
      a_sh = {a_d[WIDTH-1:0], q_d[WIDTH-1]};
      if (!a_d[WIDTH]) a_sh = a_sh - d_ext;
      else             a_sh = a_sh + d_ext;
      q_d = {q_d[WIDTH-2:0], ~a_sh[WIDTH]};
      a_d = a_sh;
    end
  end

  // Final remainder restore (result lies in [0, D), so WIDTH bits suffice) and sign fix.
  always_comb begin
    r_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + d_q) : a_q[WIDTH-1:0];
    q_fin = sq_q ? WIDTH'(-q_q) : q_q;
    r_fin = sr_q ? WIDTH'(-r_mag) : r_mag;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      sop_q       <= 1'b0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            q_q        <= dividend;
            d_q        <= divisor;
            sop_q      <= signed_op;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (d_q == '0) begin
            quo_q       <= '1;
            rem_q       <= q_q;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else if (sop_q && q_q == MIN_V && d_q == '1) begin
            quo_q       <= MIN_V;
            rem_q       <= '0;
            ovf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            a_q     <= '0;
            q_q     <= mag(q_q, sop_q);
            d_q     <= mag(d_q, sop_q);
            cnt_q   <= CNT_W'(N_ITER);
            sq_q    <= sop_q && (q_q[WIDTH-1] ^ d_q[WIDTH-1]);
            sr_q    <= sop_q && q_q[WIDTH-1];
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_CORRECT;
        end
        S_CORRECT: begin
          quo_q       <= q_fin;
          rem_q       <= r_fin;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
